// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM stage of the 5-stage MIPS pipeline:
//   - FSM state encodings for the data-memory access sequencer (IDLE, WAIT)
//   - LOAD_ABORT_DATA: value written back when a load times out
//   - mem_wb_t: MEM/WB pipeline register layout, plus its reset value
//   - mem_wb_bubble(): turns an entry into a bubble while keeping its data
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    // Access sequencer state enumeration, kept as plain constants so that
    // older flows that dislike enum types still accept it.
    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_WAIT = 1'b1;

    localparam logic [31:0] LOAD_ABORT_DATA = 32'h0000_0000;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  w_addr;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_RESET = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        w_addr:     5'd0,
        alu_result: 32'h0,
        mem_data:   32'h0
    };

    // A bubble only needs its control bits cleared; the data fields are
    // don't-care downstream, so they simply hold to avoid needless toggling.
    function automatic mem_wb_t mem_wb_bubble(input mem_wb_t cur);
        mem_wb_t b;
        b            = cur;
        b.reg_write  = 1'b0;
        b.mem_to_reg = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/mem_stage_branch_resolve.sv
// -----------------------------------------------------------------------------
// mem_stage_branch_resolve
// Purely combinational conditional-branch resolution: a branch is taken when
// any branch kind is selected and its matching compare flag is set.
// Ports:
//   gtz_in..ltz_in               compare flags from EX/MEM
//   branch_gtz_in..branch_ltz_in branch kind selects from EX/MEM
//   taken                        branch taken
// -----------------------------------------------------------------------------
module mem_stage_branch_resolve (
    input  logic gtz_in,
    input  logic ne_in,
    input  logic eq_in,
    input  logic gez_in,
    input  logic lez_in,
    input  logic ltz_in,
    input  logic branch_gtz_in,
    input  logic branch_ne_in,
    input  logic branch_eq_in,
    input  logic branch_gez_in,
    input  logic branch_lez_in,
    input  logic branch_ltz_in,
    output logic taken
);

    always_comb begin
        taken = (branch_gtz_in & gtz_in) |
                (branch_ne_in  & ne_in)  |
                (branch_eq_in  & eq_in)  |
                (branch_gez_in & gez_in) |
                (branch_lez_in & lez_in) |
                (branch_ltz_in & ltz_in);
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage MIPS pipeline. Resolves conditional branches,
// runs loads/stores on a req/ack data-memory bus (stalling upstream while the
// memory is busy, aborting after MAX_WAIT wait cycles) and owns the MEM/WB
// pipeline register. All state changes on the falling edge of clk.
//
// Parameters: MAX_WAIT (wait cycles before abort), ADDR_W (dmem address width)
// Ports:
//   clk, rst_n                    clock (falling-edge), async active-low reset
//   new_pc_in, ALU_result_in,
//   rData_reg2_in, wAddr_reg_in   EX/MEM data
//   *_in compare flags / Branch_* branch resolution inputs
//   MemWrite_in, RegWrite_in,
//   MemtoReg_in                   EX/MEM control (MemtoReg_in marks a load)
//   dmem_*                        data-memory bus
//   pc_src, branch_target         redirect to IF
//   stall                         freeze PC, IF/ID, ID/EX, EX/MEM
//   bus_err                       sticky access-timeout flag
//   wb_*                          MEM/WB pipeline register outputs
//   align_err                     (MEM_ALIGN_CHECK_EN only) misaligned-access pulse
//
// Build option: define MEM_ALIGN_CHECK_EN to suppress misaligned accesses.
//
// Bus handshake: dmem_req stays high from the first request cycle until the
// cycle in which dmem_ack is seen (inclusive); address/data/we are held by the
// frozen upstream. An ack completes the access in the cycle it is sampled.
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       new_pc_in,
    input  logic [31:0]       ALU_result_in,
    input  logic [31:0]       rData_reg2_in,
    input  logic [4:0]        wAddr_reg_in,
    input  logic              gtz_in,
    input  logic              ne_in,
    input  logic              eq_in,
    input  logic              gez_in,
    input  logic              lez_in,
    input  logic              ltz_in,
    input  logic              Branch_gtz_in,
    input  logic              Branch_ne_in,
    input  logic              Branch_eq_in,
    input  logic              Branch_gez_in,
    input  logic              Branch_lez_in,
    input  logic              Branch_ltz_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              pc_src,
    output logic [31:0]       branch_target,
    output logic              stall,
    output logic              bus_err,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [4:0]        wb_wAddr,
    output logic [31:0]       wb_ALU_result,
    output logic [31:0]       wb_mem_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    // ---------------------------------------------------------------- branch
    logic taken;

    mem_stage_branch_resolve u_branch_resolve (
        .gtz_in        (gtz_in),
        .ne_in         (ne_in),
        .eq_in         (eq_in),
        .gez_in        (gez_in),
        .lez_in        (lez_in),
        .ltz_in        (ltz_in),
        .branch_gtz_in (Branch_gtz_in),
        .branch_ne_in  (Branch_ne_in),
        .branch_eq_in  (Branch_eq_in),
        .branch_gez_in (Branch_gez_in),
        .branch_lez_in (Branch_lez_in),
        .branch_ltz_in (Branch_ltz_in),
        .taken         (taken)
    );

    assign pc_src        = taken;
    assign branch_target = new_pc_in;

    // ---------------------------------------------------------------- access
    // MemWrite_in together with MemtoReg_in is a store: dmem_we follows
    // MemWrite_in alone, so the bus sees a write.
    logic access_raw;
    logic access;

    assign access_raw = MemWrite_in | MemtoReg_in;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic align_err_q;
    logic align_err_d;

    assign misaligned  = access_raw & (ALU_result_in[1:0] != 2'b00);
    assign access      = access_raw & ~misaligned;
    assign align_err_d = misaligned;
    assign align_err   = align_err_q;
`else
    assign access = access_raw;
`endif

    assign dmem_we    = MemWrite_in;
    assign dmem_addr  = ALU_result_in[ADDR_W-1:0];
    assign dmem_wdata = rData_reg2_in;

    // ------------------------------------------------------------------- FSM
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             req_c;
    logic             stall_c;
    logic             abort_c;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        abort_c    = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                req_c = access;
                if (access && !dmem_ack) begin
                    stall_c    = 1'b1;
                    state_d    = STATE_WAIT;
                    wait_cnt_d = '0;
                end
            end
            STATE_WAIT: begin
                req_c = 1'b1;
                if (dmem_ack) begin
                    state_d = STATE_IDLE;
                end else if (wait_cnt_q == CNT_MAX) begin
                    // Timeout: drop the request in the abort cycle itself so
                    // the memory never sees a request that will not be waited on.
                    req_c     = 1'b0;
                    abort_c   = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = STATE_IDLE;
                end else begin
                    stall_c    = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // Gated by rst_n so the request and stall drop as soon as reset asserts,
    // even while the upstream still presents an access.
    assign dmem_req = rst_n & req_c;
    assign stall    = rst_n & stall_c;
    assign bus_err  = bus_err_q;

    // --------------------------------------------------------------- MEM/WB
    mem_wb_t mem_wb_q, mem_wb_d;

    always_comb begin
        mem_wb_d = mem_wb_q;
        if (stall_c) begin
            mem_wb_d = mem_wb_bubble(mem_wb_q);
        end else begin
            mem_wb_d.reg_write  = RegWrite_in;
            mem_wb_d.mem_to_reg = MemtoReg_in;
            mem_wb_d.w_addr     = wAddr_reg_in;
            mem_wb_d.alu_result = ALU_result_in;
            if (abort_c) begin
                mem_wb_d.mem_data = LOAD_ABORT_DATA;
            end else if (dmem_ack) begin
                mem_wb_d.mem_data = dmem_rdata;
            end else begin
                mem_wb_d.mem_data = 32'h0;
            end
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned) begin
                mem_wb_d.reg_write = 1'b0;
            end
`endif
        end
    end

    assign wb_RegWrite   = mem_wb_q.reg_write;
    assign wb_MemtoReg   = mem_wb_q.mem_to_reg;
    assign wb_wAddr      = mem_wb_q.w_addr;
    assign wb_ALU_result = mem_wb_q.alu_result;
    assign wb_mem_data   = mem_wb_q.mem_data;

    // ------------------------------------------------------------ registers
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_IDLE;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
            mem_wb_q   <= MEM_WB_RESET;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
            mem_wb_q   <= mem_wb_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage. The DUT updates on the falling edge, so
// inputs are driven 1 ns after a falling edge, combinational outputs are
// sampled 1 ns after the rising edge and registered outputs 1 ns after the
// next falling edge. Define MEM_ALIGN_CHECK_EN to also cover the align check.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] new_pc_in, ALU_result_in, rData_reg2_in, dmem_rdata;
    logic [4:0]  wAddr_reg_in;
    logic gtz_in, ne_in, eq_in, gez_in, lez_in, ltz_in;
    logic Branch_gtz_in, Branch_ne_in, Branch_eq_in, Branch_gez_in, Branch_lez_in, Branch_ltz_in;
    logic MemWrite_in, RegWrite_in, MemtoReg_in, dmem_ack;
    logic        dmem_req, dmem_we, pc_src, stall, bus_err, wb_RegWrite, wb_MemtoReg;
    logic [31:0] dmem_addr, dmem_wdata, branch_target, wb_ALU_result, wb_mem_data;
    logic [4:0]  wb_wAddr;
`ifdef MEM_ALIGN_CHECK_EN
    logic align_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage #(.MAX_WAIT(15), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .new_pc_in(new_pc_in), .ALU_result_in(ALU_result_in),
        .rData_reg2_in(rData_reg2_in), .wAddr_reg_in(wAddr_reg_in),
        .gtz_in(gtz_in), .ne_in(ne_in), .eq_in(eq_in),
        .gez_in(gez_in), .lez_in(lez_in), .ltz_in(ltz_in),
        .Branch_gtz_in(Branch_gtz_in), .Branch_ne_in(Branch_ne_in),
        .Branch_eq_in(Branch_eq_in), .Branch_gez_in(Branch_gez_in),
        .Branch_lez_in(Branch_lez_in), .Branch_ltz_in(Branch_ltz_in),
        .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .pc_src(pc_src), .branch_target(branch_target), .stall(stall), .bus_err(bus_err),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_wAddr(wb_wAddr),
        .wb_ALU_result(wb_ALU_result), .wb_mem_data(wb_mem_data)
`ifdef MEM_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    // --------------------------------------------------------- driver tasks
    task automatic set_idle();
        new_pc_in = 32'h0; ALU_result_in = 32'h0; rData_reg2_in = 32'h0; dmem_rdata = 32'h0;
        wAddr_reg_in = 5'd0;
        gtz_in = 0; ne_in = 0; eq_in = 0; gez_in = 0; lez_in = 0; ltz_in = 0;
        Branch_gtz_in = 0; Branch_ne_in = 0; Branch_eq_in = 0;
        Branch_gez_in = 0; Branch_lez_in = 0; Branch_ltz_in = 0;
        MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 0; dmem_ack = 0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] waddr,
                              input logic ack, input logic [31:0] rdata);
        set_idle();
        MemtoReg_in = 1; RegWrite_in = 1; ALU_result_in = addr;
        wAddr_reg_in = waddr; dmem_ack = ack; dmem_rdata = rdata;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        #3;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", dmem_req); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b expected 0", bus_err); else n_pass++;
        n_checks++; if ({wb_RegWrite, wb_MemtoReg, wb_wAddr} !== 7'd0)
            $display("FAIL reset_wb_ctrl: got %b%b %h expected 0", wb_RegWrite, wb_MemtoReg, wb_wAddr); else n_pass++;
        n_checks++; if ({wb_ALU_result, wb_mem_data} !== 64'd0)
            $display("FAIL reset_wb_data: got %h %h expected 0", wb_ALU_result, wb_mem_data); else n_pass++;
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_branch();
        @(negedge clk); #1;
        Branch_eq_in = 1; eq_in = 1; new_pc_in = 32'h0000_0040;
        #1;
        n_checks++; if (pc_src !== 1'b1) $display("FAIL br_eq_taken: got %b expected 1", pc_src); else n_pass++;
        n_checks++; if (branch_target !== 32'h40) $display("FAIL br_target: got %h expected 00000040", branch_target); else n_pass++;
        eq_in = 0;
        #1;
        n_checks++; if (pc_src !== 1'b0) $display("FAIL br_eq_not_taken: got %b expected 0", pc_src); else n_pass++;
        Branch_eq_in = 0; Branch_ltz_in = 1; ltz_in = 1;
        #1;
        n_checks++; if (pc_src !== 1'b1) $display("FAIL br_ltz_taken: got %b expected 1", pc_src); else n_pass++;
        // Flag set for a different kind than the one selected: not taken.
        Branch_ltz_in = 0; ltz_in = 0; Branch_gtz_in = 1; ne_in = 1;
        #1;
        n_checks++; if (pc_src !== 1'b0) $display("FAIL br_kind_mismatch: got %b expected 0", pc_src); else n_pass++;
        set_idle();
    endtask

    task automatic test_load_zero_wait();
        @(negedge clk); #1;
        drive_load(32'h0000_0100, 5'd5, 1'b1, 32'hCAFE_F00D);
        @(posedge clk); #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL ld0_stall: got %b expected 0", stall); else n_pass++;
        n_checks++; if ({dmem_req, dmem_we} !== 2'b10) $display("FAIL ld0_req_we: got %b%b expected 10", dmem_req, dmem_we); else n_pass++;
        n_checks++; if (dmem_addr !== 32'h100) $display("FAIL ld0_addr: got %h expected 00000100", dmem_addr); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (wb_mem_data !== 32'hCAFE_F00D) $display("FAIL ld0_wb_data: got %h expected cafef00d", wb_mem_data); else n_pass++;
        n_checks++; if ({wb_RegWrite, wb_MemtoReg} !== 2'b11) $display("FAIL ld0_wb_ctrl: got %b%b expected 11", wb_RegWrite, wb_MemtoReg); else n_pass++;
        n_checks++; if (wb_wAddr !== 5'd5) $display("FAIL ld0_wb_waddr: got %0d expected 5", wb_wAddr); else n_pass++;
        set_idle();
    endtask

    task automatic test_store_wait();
        int req_cnt = 0;
        int stall_cnt = 0;
        @(negedge clk); #1;
        // RegWrite_in held high so that the bubbles are visible on wb_RegWrite.
        MemWrite_in = 1; RegWrite_in = 1; ALU_result_in = 32'h0000_0200;
        rData_reg2_in = 32'h1234_5678; dmem_rdata = 32'h0000_0BAD; wAddr_reg_in = 5'd6;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            @(posedge clk); #1;
            if (dmem_req) req_cnt++;
            if (stall) stall_cnt++;
            if (i == 0) begin
                n_checks++; if ({dmem_we, dmem_wdata} !== {1'b1, 32'h1234_5678})
                    $display("FAIL st_bus: got %b %h expected 1 12345678", dmem_we, dmem_wdata); else n_pass++;
            end
            @(negedge clk); #1;
            if (i < 3) begin
                n_checks++; if ({wb_RegWrite, wb_ALU_result} !== {1'b0, 32'h0})
                    $display("FAIL st_bubble%0d: got %b %h expected 0 00000000", i, wb_RegWrite, wb_ALU_result); else n_pass++;
            end
        end
        n_checks++; if (req_cnt != 4) $display("FAIL st_req_cycles: got %0d expected 4", req_cnt); else n_pass++;
        n_checks++; if (stall_cnt != 3) $display("FAIL st_stall_cycles: got %0d expected 3", stall_cnt); else n_pass++;
        n_checks++; if ({wb_RegWrite, wb_MemtoReg, wb_ALU_result} !== {2'b10, 32'h200})
            $display("FAIL st_entry: got %b%b %h expected 10 00000200", wb_RegWrite, wb_MemtoReg, wb_ALU_result); else n_pass++;
        n_checks++; if (wb_mem_data !== 32'h0BAD) $display("FAIL st_wb_data: got %h expected 00000bad", wb_mem_data); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL st_bus_err: got %b expected 0", bus_err); else n_pass++;
        set_idle();
    endtask

    task automatic test_timeout();
        int  stall_cnt = 0;
        logic done = 1'b0;
        @(negedge clk); #1;
        drive_load(32'h0000_0300, 5'd7, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (stall) begin
                stall_cnt++;
                @(negedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        n_checks++; if (done !== 1'b1) $display("FAIL to_stall_release: got stuck expected release"); else n_pass++;
        n_checks++; if (stall_cnt != 16) $display("FAIL to_stall_cycles: got %0d expected 16", stall_cnt); else n_pass++;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL to_req_dropped: got %b expected 0", dmem_req); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus_err !== 1'b1) $display("FAIL to_bus_err: got %b expected 1", bus_err); else n_pass++;
        n_checks++; if (wb_mem_data !== 32'h0) $display("FAIL to_wb_data: got %h expected 00000000", wb_mem_data); else n_pass++;
        n_checks++; if ({wb_RegWrite, wb_wAddr} !== {1'b1, 5'd7})
            $display("FAIL to_wb_entry: got %b %0d expected 1 7", wb_RegWrite, wb_wAddr); else n_pass++;
        set_idle();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus_err !== 1'b1) $display("FAIL to_bus_err_sticky: got %b expected 1", bus_err); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int  stall_cnt;
        logic done = 1'b0;
        @(negedge clk); #1;
        set_idle();
        RegWrite_in = 1; wAddr_reg_in = 5'd9; ALU_result_in = 32'h0000_0055;
        @(negedge clk); #1;
        drive_load(32'h0000_0400, 5'd3, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        n_checks++; if ({stall, wb_wAddr} !== {1'b1, 5'd9})
            $display("FAIL rw_pre: got %b %0d expected 1 9", stall, wb_wAddr); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({dmem_req, stall} !== 2'b00) $display("FAIL rw_req_stall: got %b%b expected 00", dmem_req, stall); else n_pass++;
        n_checks++; if ({wb_RegWrite, wb_MemtoReg, wb_wAddr, wb_ALU_result, wb_mem_data} !== 71'd0)
            $display("FAIL rw_wb: got %b%b %h %h %h expected all 0", wb_RegWrite, wb_MemtoReg, wb_wAddr, wb_ALU_result, wb_mem_data); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL rw_bus_err: got %b expected 0", bus_err); else n_pass++;
        #1;
        rst_n = 1'b1;
        #1;
        // Restarting from IDLE with a cleared counter gives the full 16 stall cycles again.
        stall_cnt = stall ? 1 : 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            @(posedge clk); #1;
            if (stall) stall_cnt++;
            else done = 1'b1;
        end
        n_checks++; if (stall_cnt != 16) $display("FAIL rw_restart_cycles: got %0d expected 16", stall_cnt); else n_pass++;
        @(negedge clk); #1;
        set_idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr_t [3] = '{32'h10, 32'h14, 32'h99};
        logic [31:0] rdat_t [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        logic [4:0]  wa_t   [3] = '{5'd1, 5'd2, 5'd4};
        logic        ld_t   [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] exp_data [3] = '{32'h1111_1111, 32'h2222_2222, 32'h0};
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            RegWrite_in = 1; MemtoReg_in = ld_t[i]; dmem_ack = ld_t[i];
            ALU_result_in = addr_t[i]; dmem_rdata = rdat_t[i]; wAddr_reg_in = wa_t[i];
            @(posedge clk); #1;
            n_checks++; if (stall !== 1'b0) $display("FAIL b2b_stall%0d: got %b expected 0", i, stall); else n_pass++;
            @(negedge clk); #1;
            n_checks++; if ({wb_MemtoReg, wb_wAddr, wb_ALU_result, wb_mem_data} !== {ld_t[i], wa_t[i], addr_t[i], exp_data[i]})
                $display("FAIL b2b_entry%0d: got %b %0d %h %h expected %b %0d %h %h", i,
                         wb_MemtoReg, wb_wAddr, wb_ALU_result, wb_mem_data, ld_t[i], wa_t[i], addr_t[i], exp_data[i]);
            else n_pass++;
        end
        set_idle();
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        @(negedge clk); #1;
        drive_load(32'h0000_0102, 5'd8, 1'b0, 32'h0);
        @(posedge clk); #1;
        n_checks++; if ({dmem_req, stall} !== 2'b00) $display("FAIL al_req_stall: got %b%b expected 00", dmem_req, stall); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (align_err !== 1'b1) $display("FAIL al_pulse: got %b expected 1", align_err); else n_pass++;
        n_checks++; if (wb_RegWrite !== 1'b0) $display("FAIL al_wb_regwrite: got %b expected 0", wb_RegWrite); else n_pass++;
        set_idle();
        @(negedge clk); #1;
        n_checks++; if (align_err !== 1'b0) $display("FAIL al_pulse_end: got %b expected 0", align_err); else n_pass++;
    endtask
`endif

    // ---------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_branch();
        test_load_zero_wait();
        test_store_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 ns");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline register outputs.
- Resolves conditional branches and drives the redirect to IF.
- Runs load/store accesses on a req/ack data-memory bus, stalling the pipeline while the memory is busy.
- Owns the MEM/WB pipeline register.

Parameters:
- MAX_WAIT, 15, number of WAIT cycles without ack before the access is aborted.
- ADDR_W, 32, data-memory address width; upper bits of ALU_result_in are truncated.

Ports:
- clk  in  1  pipeline clock; all state updates on its falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- new_pc_in  in  32  branch target from EX/MEM.
- ALU_result_in  in  32  memory address, or result to pass through.
- rData_reg2_in  in  32  store data.
- wAddr_reg_in  in  5  destination register.
- gtz_in, ne_in, eq_in, gez_in, lez_in, ltz_in  in  1 each  compare flags.
- Branch_gtz_in, Branch_ne_in, Branch_eq_in, Branch_gez_in, Branch_lez_in, Branch_ltz_in  in  1 each  branch kind.
- MemWrite_in, RegWrite_in, MemtoReg_in  in  1 each  control; MemtoReg_in=1 marks a load.
- dmem_ack  in  1  memory completion.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_W  address.
- dmem_wdata  out  32  store data.
- pc_src  out  1  take branch.
- branch_target  out  32  redirect PC.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- bus_err  out  1  sticky timeout flag.
- wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB control.
- wb_wAddr  out  5  MEM/WB destination register.
- wb_ALU_result, wb_mem_data  out  32 each  MEM/WB data.

Behaviour:
- Branch resolution:
  - Combinational: taken = OR over k of (Branch_k_in & k_in); pc_src = taken; branch_target = new_pc_in.
  - Flushing younger stages is the hazard unit's job.
- Access definition: access = MemWrite_in | MemtoReg_in. Simultaneous MemWrite_in and MemtoReg_in is treated as a store.
- Bus outputs:
  - dmem_we = MemWrite_in; dmem_addr = ALU_result_in[ADDR_W-1:0]; dmem_wdata = rData_reg2_in.
  - These stay stable during WAIT because upstream is frozen by stall.
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req = access. If access & ~dmem_ack, go to WAIT and set wait_cnt=0. An ack in the same cycle completes with zero wait.
  - WAIT: dmem_req=1; wait_cnt increments each edge.
    - On dmem_ack: complete and return to IDLE.
    - On wait_cnt==MAX_WAIT with no ack: abort. Drop dmem_req, set bus_err, load data = 32'h0, return to IDLE.
- stall (combinational): (IDLE & access & ~dmem_ack) | (WAIT & ~dmem_ack & wait_cnt!=MAX_WAIT).
- MEM/WB register, on each falling edge:
  - If stall: insert a bubble (wb_RegWrite=0, wb_MemtoReg=0); data fields are don't-care and hold their value.
  - Otherwise: latch RegWrite_in, MemtoReg_in, wAddr_reg_in, ALU_result_in; wb_mem_data = dmem_rdata on ack, else 0.
- Latency: MEM result reaches MEM/WB one falling edge after the access completes.
- Reset (also mid-access): every output register goes to 0, FSM to IDLE, wait_cnt=0, bus_err=0. dmem_req deasserts immediately.
- bus_err clears only on reset.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an access with ALU_result_in[1:0]!=0 is suppressed.
  - No dmem_req and no stall.
  - Extra output align_err pulses high for one cycle (registered).
  - The MEM/WB entry is latched with wb_RegWrite=0.
- Undefined: no check, no align_err port; the address is passed through unchanged.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum (IDLE, WAIT)
  - LOAD_ABORT_DATA = 32'h0
  - MEM/WB bubble/reset constants
- One natural sub-module: branch_resolve, purely combinational flags -> taken.

Test Plan:
- Branch_eq_in=1, eq_in=1, new_pc_in=32'h0000_0040 -> pc_src=1, branch_target=32'h40. Same with eq_in=0 -> pc_src=0.
- Load, ack in same cycle, dmem_rdata=32'hCAFE_F00D, wAddr_reg_in=5 -> stall never high; next falling edge wb_mem_data=32'hCAFEF00D, wb_MemtoReg=1, wb_wAddr=5.
- Store, ack after 3 cycles -> dmem_req/dmem_we high 4 cycles, stall high 3 cycles, 3 bubbles with wb_RegWrite=0, then ALU entry latched.
- No ack, MAX_WAIT=15 -> stall drops after 16 cycles, bus_err=1 and sticky, wb_mem_data=0.
- rst_n low during WAIT -> dmem_req, stall and all wb_* go to 0 without a clock edge; FSM restarts in IDLE.
- With MEM_ALIGN_CHECK_EN, load at 32'h0000_0102 -> no dmem_req, align_err one-cycle pulse, wb_RegWrite=0.
